// File: rtl/stream_group_accum_pkg.sv
// Shared types and constants for the stream group accumulator.
// Includes state encoding, default word width, and the drop counter width.
package stream_group_accum_pkg;

    localparam int DIN_W_DEF  = 11;
    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Ceiling log2. Evaluated at elaboration time for widths; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_n.sv
// First-word-fall-through synchronous FIFO. The head word is visible on rd_data whenever empty_n is high.
// A write while full is dropped, even if a pop happens in the same cycle.
module sync_fifo_fwft_n
    import stream_group_accum_pkg::*;
#(
    parameter int W     = 11,
    parameter int DEPTH = 8,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ce,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full_n,
    output logic             empty_n
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full_n  = (r_count != CNT_W'(DEPTH));
    assign empty_n = (r_count != '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_push = ce & wr_en & full_n;
    assign w_pop  = ce & rd_en & empty_n;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Depth is a power of two, so pointers wrap naturally at PTR_W bits.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/stream_group_accum.sv
// Buffers an adder output stream and sums fixed groups of GROUP_N words onto an ap_fifo read port.
// Optional drop counter output enabled by STREAM_GROUP_ACCUM_DROP_CNT_EN.
module stream_group_accum
    import stream_group_accum_pkg::*;
#(
    parameter int DIN_W   = DIN_W_DEF,
    parameter int GROUP_N = 4,
    parameter int DEPTH   = 8,
    localparam int SUM_W  = DIN_W + clog2(GROUP_N)
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_ce,
    input  logic [DIN_W-1:0]      din,
    input  logic                  din_write,
    output logic                  din_full_n,
    output logic [SUM_W-1:0]      dout,
    output logic                  dout_empty_n,
    input  logic                  dout_read,
`ifdef STREAM_GROUP_ACCUM_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic                  ap_idle
);

    localparam int IDX_W = clog2(GROUP_N);
    localparam int CNT_W = clog2(DEPTH) + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic [SUM_W-1:0]   r_acc;
    logic [SUM_W-1:0]   w_acc_next;
    logic [SUM_W-1:0]   r_dout;
    logic [SUM_W-1:0]   w_dout_next;
    logic               r_dout_empty_n;
    logic               w_dout_empty_n_next;
    logic               w_pop;
    logic [DIN_W-1:0]   w_fifo_dout;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_full_n;
    logic               w_fifo_empty_n;
    logic [SUM_W-1:0]   w_word_ext;
    logic [SUM_W-1:0]   w_sum;

    sync_fifo_fwft_n #(
        .W     (DIN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .srst    (ap_rst),
        .ce      (ap_ce),
        .wr_en   (din_write),
        .wr_data (din),
        .rd_en   (w_pop),
        .rd_data (w_fifo_dout),
        .count   (w_fifo_count),
        .full_n  (w_fifo_full_n),
        .empty_n (w_fifo_empty_n)
    );

    // First word of a group restarts the accumulator instead of adding to it.
    assign w_word_ext = SUM_W'(w_fifo_dout);
    assign w_sum      = (r_idx == '0) ? w_word_ext : (r_acc + w_word_ext);

    always_comb begin
        w_state_next        = r_state;
        w_idx_next          = r_idx;
        w_acc_next          = r_acc;
        w_dout_next         = r_dout;
        w_dout_empty_n_next = r_dout_empty_n;
        w_pop               = 1'b0;
        if (ap_ce) begin
            case (r_state)
                ACC: begin
                    if (w_fifo_empty_n) begin
                        w_pop      = 1'b1;
                        w_acc_next = w_sum;
                        if (r_idx == IDX_W'(GROUP_N - 1)) begin
                            w_idx_next          = '0;
                            w_dout_next         = w_sum;
                            w_dout_empty_n_next = 1'b1;
                            w_state_next        = HOLD;
                        end else begin
                            w_idx_next = r_idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (dout_read) begin
                        w_dout_empty_n_next = 1'b0;
                        w_state_next        = ACC;
                    end
                end
                default: w_state_next = ACC;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state        <= ACC;
            r_idx          <= '0;
            r_acc          <= '0;
            r_dout         <= '0;
            r_dout_empty_n <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_idx          <= w_idx_next;
            r_acc          <= w_acc_next;
            r_dout         <= w_dout_next;
            r_dout_empty_n <= w_dout_empty_n_next;
        end
    end

    assign din_full_n   = w_fifo_full_n;
    assign dout         = r_dout;
    assign dout_empty_n = r_dout_empty_n;
    assign ap_idle      = (r_state == ACC) & (w_fifo_count == '0) & (r_idx == '0);

`ifdef STREAM_GROUP_ACCUM_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_drop_cnt <= '0;
        end else if (ap_ce & din_write & ~w_fifo_full_n & (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_stream_group_accum.sv
// Directed bench for stream_group_accum with GROUP_N=4, DEPTH=8, DIN_W=11.
// Define STREAM_GROUP_ACCUM_DROP_CNT_EN to also exercise the drop counter.
module tb_stream_group_accum;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_ce;
    logic [10:0] din;
    logic        din_write;
    logic        din_full_n;
    logic [12:0] dout;
    logic        dout_empty_n;
    logic        dout_read;
    logic        ap_idle;
`ifdef STREAM_GROUP_ACCUM_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    stream_group_accum dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .ap_ce        (ap_ce),
        .din          (din),
        .din_write    (din_write),
        .din_full_n   (din_full_n),
        .dout         (dout),
        .dout_empty_n (dout_empty_n),
        .dout_read    (dout_read),
`ifdef STREAM_GROUP_ACCUM_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .ap_idle      (ap_idle)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [10:0] word);
        din       = word;
        din_write = 1'b1;
        step();
    endtask

    // Wait (bounded) for a sum, compare it, then consume it with a one-cycle read pulse.
    task automatic read_expect(input string tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!dout_empty_n && n < 50) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(dout_empty_n), 32'd1);
        check(tag, 32'(dout), exp);
        $display("read %s: dout=%0d", tag, dout);
        dout_read = 1'b1;
        step();
        dout_read = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_sum [4];
        int k;

        ap_rst    = 1'b1;
        ap_ce     = 1'b1;
        din       = '0;
        din_write = 1'b0;
        dout_read = 1'b0;
        step();
        step();
        ap_rst = 1'b0;
        check("rst_empty_n", 32'(dout_empty_n), 32'd0);
        check("rst_full_n",  32'(din_full_n),   32'd1);
        check("rst_idle",    32'(ap_idle),      32'd1);
        check("rst_dout",    32'(dout),         32'd0);
`ifdef STREAM_GROUP_ACCUM_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif

        // Group 1..4: sum appears two cycles after the last write.
        wr(11'd1);
        wr(11'd2);
        wr(11'd3);
        wr(11'd4);
        din_write = 1'b0;
        check("lat_not_yet", 32'(dout_empty_n), 32'd0);
        check("busy_idle",   32'(ap_idle),      32'd0);
        step();
        check("lat_valid", 32'(dout_empty_n), 32'd1);
        check("sum_1234",  32'(dout),         32'd10);
        step();
        step();
        step();
        check("hold_valid", 32'(dout_empty_n), 32'd1);
        check("hold_dout",  32'(dout),         32'd10);
        dout_read = 1'b1;
        step();
        dout_read = 1'b0;
        check("read_clears",    32'(dout_empty_n), 32'd0);
        check("read_dout_held", 32'(dout),         32'd10);
        check("read_idle",      32'(ap_idle),      32'd1);
        $display("read sum_1234: dout=10");

        // Maximum words: no wrap of the 13-bit sum.
        for (int i = 0; i < 4; i++) wr(11'd2047);
        din_write = 1'b0;
        read_expect("sum_max", 32'd8188);

        // Overfill while HOLD blocks pops: 13 writes, the 13th is dropped.
        for (int i = 0; i < 13; i++) wr(11'(i + 1));
        din_write = 1'b0;
        check("ovf_full_n", 32'(din_full_n), 32'd0);
`ifdef STREAM_GROUP_ACCUM_DROP_CNT_EN
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
        read_expect("ovf_g1", 32'd10);
        read_expect("ovf_g2", 32'd26);
        read_expect("ovf_g3", 32'd42);
        check("ovf_idle", 32'(ap_idle), 32'd1);

        // Clock enable low mid-group: writes ignored, state frozen, reads ignored.
        wr(11'd3);
        wr(11'd4);
        din_write = 1'b0;
        step();
        ap_ce     = 1'b0;
        din       = 11'd100;
        din_write = 1'b1;
        step();
        step();
        step();
        din_write = 1'b0;
        ap_ce     = 1'b1;
        check("ce_idle", 32'(ap_idle), 32'd0);
        wr(11'd5);
        wr(11'd6);
        din_write = 1'b0;
        step();
        check("ce_sum_valid", 32'(dout_empty_n), 32'd1);
        check("ce_sum", 32'(dout), 32'd18);
        ap_ce     = 1'b0;
        dout_read = 1'b1;
        step();
        check("ce_read_ignored", 32'(dout_empty_n), 32'd1);
        ap_ce = 1'b1;
        step();
        dout_read = 1'b0;
        check("ce_read_taken", 32'(dout_empty_n), 32'd0);
        $display("read ce_sum: dout=18");

        // Reset mid-group discards the partial sum.
        wr(11'd7);
        wr(11'd7);
        din_write = 1'b0;
        step();
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        check("midrst_idle", 32'(ap_idle), 32'd1);
        check("midrst_dout", 32'(dout),    32'd0);
        for (int i = 0; i < 4; i++) wr(11'd5);
        din_write = 1'b0;
        read_expect("midrst_sum", 32'd20);

        // Streaming: a write and a read request every cycle, across pointer wraps.
        exp_sum[0] = 32'd628;
        exp_sum[1] = 32'd2228;
        exp_sum[2] = 32'd3828;
        exp_sum[3] = 32'd5428;
        k = 0;
        dout_read = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c < 16) begin
                din       = 11'(c * 100 + 7);
                din_write = 1'b1;
            end else begin
                din_write = 1'b0;
            end
            step();
            if (dout_empty_n) begin
                if (k < 4) begin
                    check($sformatf("stream_g%0d", k), 32'(dout), exp_sum[k]);
                    $display("read stream_g%0d: dout=%0d", k, dout);
                end
                k++;
            end
        end
        dout_read = 1'b0;
        check("stream_groups", 32'(k), 32'd4);
        check("stream_idle", 32'(ap_idle), 32'd1);
`ifdef STREAM_GROUP_ACCUM_DROP_CNT_EN
        check("stream_no_drop", 32'(drop_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
